// File: rtl/bidir_shift_loader_if.sv
// Word-load handshake plus serial drive toward the bidirectional shift register.
// BIDIR_SHIFT_LOADER_CHECK_EN adds the register read-back (i_q) and the o_err flag.
interface bidir_shift_loader_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] i_data;
    logic             i_dir;
    logic             i_valid;
    logic             o_ready;
    logic             o_d;
    logic             o_right;
    logic             o_shift_en;
    logic             o_done;
`ifdef BIDIR_SHIFT_LOADER_CHECK_EN
    logic [WIDTH-1:0] i_q;
    logic             o_err;

    modport master (
        output i_data, i_dir, i_valid, i_q,
        input  o_ready, o_d, o_right, o_shift_en, o_done, o_err
    );

    modport slave (
        input  i_data, i_dir, i_valid, i_q,
        output o_ready, o_d, o_right, o_shift_en, o_done, o_err
    );
`else
    modport master (
        output i_data, i_dir, i_valid,
        input  o_ready, o_d, o_right, o_shift_en, o_done
    );

    modport slave (
        input  i_data, i_dir, i_valid,
        output o_ready, o_d, o_right, o_shift_en, o_done
    );
`endif
endinterface

// File: rtl/bidir_shift_loader.sv
// Serializes a parallel word into a WIDTH-bit bidirectional shift register.
// Optional read-back compare enabled by the macro BIDIR_SHIFT_LOADER_CHECK_EN.
module bidir_shift_loader #(
    parameter int WIDTH = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    bidir_shift_loader_if.slave    bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [WIDTH-1:0] sreg_reg, sreg_next;
    logic             ready_reg, ready_next;
    logic             d_reg, d_next;
    logic             right_reg, right_next;
    logic             shift_en_reg, shift_en_next;
    logic             done_reg, done_next;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            sreg_reg     <= '0;
            ready_reg    <= 1'b1;
            d_reg        <= 1'b0;
            right_reg    <= 1'b1;
            shift_en_reg <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            sreg_reg     <= sreg_next;
            ready_reg    <= ready_next;
            d_reg        <= d_next;
            right_reg    <= right_next;
            shift_en_reg <= shift_en_next;
            done_reg     <= done_next;
        end
    end

    // Outputs are computed one cycle ahead so every port comes straight from a flop.
    // sreg_reg holds the bits still to send, with the next bit at the end facing the register.
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        sreg_next     = sreg_reg;
        ready_next    = 1'b0;
        d_next        = 1'b0;
        right_next    = right_reg;
        shift_en_next = 1'b0;
        done_next     = 1'b0;
        case (state_reg)
            IDLE: begin
                ready_next = 1'b1;
                if (bus.i_valid && ready_reg) begin
                    state_next    = SHIFT;
                    cnt_next      = '0;
                    sreg_next     = bus.i_data;
                    right_next    = bus.i_dir;
                    ready_next    = 1'b0;
                    shift_en_next = 1'b1;
                    d_next        = bus.i_dir ? bus.i_data[WIDTH-1] : bus.i_data[0];
                end
            end
            SHIFT: begin
                if (cnt_reg == LAST) begin
                    state_next = DONE;
                    done_next  = 1'b1;
                end else begin
                    cnt_next      = cnt_reg + CW'(1);
                    sreg_next     = right_reg ? {sreg_reg[WIDTH-2:0], 1'b0}
                                              : {1'b0, sreg_reg[WIDTH-1:1]};
                    shift_en_next = 1'b1;
                    d_next        = right_reg ? sreg_next[WIDTH-1] : sreg_next[0];
                end
            end
            DONE: begin
                state_next = IDLE;
                ready_next = 1'b1;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.o_ready    = ready_reg;
    assign bus.o_d        = d_reg;
    assign bus.o_right    = right_reg;
    assign bus.o_shift_en = shift_en_reg;
    assign bus.o_done     = done_reg;

`ifdef BIDIR_SHIFT_LOADER_CHECK_EN
    logic [WIDTH-1:0] word_reg;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            word_reg <= '0;
        end else if (state_reg == IDLE && bus.i_valid && ready_reg) begin
            word_reg <= bus.i_data;
        end
    end

    // The register only holds the complete word during the DONE cycle, so the
    // flag gates the flopped done with a compare against the register's own flops.
    assign bus.o_err = done_reg && (bus.i_q != word_reg);
`endif

endmodule
